// File: rtl/exec_arbiter.sv
// Two-requester arbiter in front of a single execute stage.
// Each operation is granted in IDLE, presented to the ALU for one ISSUE
// cycle, and its result is held in RESP until the consumer accepts it.
module exec_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [134:0] req0_data_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [134:0] req1_data_i,
  output logic [4:0]  alu_opcode_o,
  output logic        op_A_sel_o,
  output logic        op_B_sel_o,
  output logic [31:0] current_pc_o,
  output logic [31:0] rD1_o,
  output logic [31:0] rD2_o,
  output logic [31:0] ext_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_branch_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic        resp_id_o,
  output logic [31:0] resp_result_o,
  output logic        resp_branch_o,
  output logic        busy_o
);

  localparam int unsigned DATA_W = 135;
  localparam int unsigned XLEN   = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   payload_q;
  logic                last_grant_q;  // id of the most recent grant
  logic                resp_valid_q;
  logic                resp_id_q;
  logic                resp_branch_q;
  logic [XLEN-1:0]     resp_result_q;
  logic                busy_q;
  logic                grant0_c;
  logic                grant1_c;

  // Grant decision: only in IDLE and out of reset; ties go round-robin or to req0
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (rst_n_i && (state_q == S_IDLE)) begin
      if (req0_valid_i && req1_valid_i) begin
        if (RR_EN && !last_grant_q) grant1_c = 1'b1;
        else                        grant0_c = 1'b1;
      end else if (req0_valid_i) begin
        grant0_c = 1'b1;
      end else if (req1_valid_i) begin
        grant1_c = 1'b1;
      end
    end
  end

  assign req0_ready_o = grant0_c;
  assign req1_ready_o = grant1_c;

  // Operation FSM with payload and response registers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      payload_q     <= '0;
      last_grant_q  <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_branch_q <= 1'b0;
      resp_result_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant0_c || grant1_c) begin
            payload_q    <= grant1_c ? req1_data_i : req0_data_i;
            last_grant_q <= grant1_c;
            state_q      <= S_ISSUE;
            busy_q       <= 1'b1;
          end
        end
        S_ISSUE: begin
          resp_result_q <= alu_result_i;
          resp_branch_q <= alu_branch_i;
          resp_id_q     <= last_grant_q;
          resp_valid_q  <= 1'b1;
          state_q       <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Execute operands come straight from the payload register
  assign alu_opcode_o  = payload_q[134:130];
  assign op_A_sel_o    = payload_q[129];
  assign op_B_sel_o    = payload_q[128];
  assign current_pc_o  = payload_q[127:96];
  assign rD1_o         = payload_q[95:64];
  assign rD2_o         = payload_q[63:32];
  assign ext_o         = payload_q[31:0];

  assign resp_valid_o  = resp_valid_q;
  assign resp_id_o     = resp_id_q;
  assign resp_result_o = resp_result_q;
  assign resp_branch_o = resp_branch_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_exec_arbiter.sv
// Directed bench for exec_arbiter: a round-robin and a fixed-priority
// instance share the same request stimulus, each with its own ALU stub.
module tb_exec_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         v0, v1, resp_ready;
  logic [134:0] d0, d1;

  logic         rr_rdy0, rr_rdy1, fp_rdy0, fp_rdy1;
  logic [4:0]   rr_opc, fp_opc;
  logic         rr_asel, rr_bsel, fp_asel, fp_bsel;
  logic [31:0]  rr_pc, rr_r1, rr_r2, rr_ext, fp_pc, fp_r1, fp_r2, fp_ext;
  logic [31:0]  rr_alu, fp_alu, rr_res, fp_res;
  logic         rr_br_in, fp_br_in, rr_rv, fp_rv, rr_id, fp_id, rr_br, fp_br;
  logic         rr_busy, fp_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // ALU stubs: sum of the two register operands, branch when they are equal
  assign rr_alu   = rr_r1 + rr_r2;
  assign rr_br_in = (rr_r1 == rr_r2);
  assign fp_alu   = fp_r1 + fp_r2;
  assign fp_br_in = (fp_r1 == fp_r2);

  exec_arbiter #(.RR_EN(1'b1)) u_rr (
    .clk_i(clk), .rst_n_i(rst_n),
    .req0_valid_i(v0), .req0_ready_o(rr_rdy0), .req0_data_i(d0),
    .req1_valid_i(v1), .req1_ready_o(rr_rdy1), .req1_data_i(d1),
    .alu_opcode_o(rr_opc), .op_A_sel_o(rr_asel), .op_B_sel_o(rr_bsel),
    .current_pc_o(rr_pc), .rD1_o(rr_r1), .rD2_o(rr_r2), .ext_o(rr_ext),
    .alu_result_i(rr_alu), .alu_branch_i(rr_br_in),
    .resp_valid_o(rr_rv), .resp_ready_i(resp_ready),
    .resp_id_o(rr_id), .resp_result_o(rr_res), .resp_branch_o(rr_br),
    .busy_o(rr_busy)
  );

  exec_arbiter #(.RR_EN(1'b0)) u_fp (
    .clk_i(clk), .rst_n_i(rst_n),
    .req0_valid_i(v0), .req0_ready_o(fp_rdy0), .req0_data_i(d0),
    .req1_valid_i(v1), .req1_ready_o(fp_rdy1), .req1_data_i(d1),
    .alu_opcode_o(fp_opc), .op_A_sel_o(fp_asel), .op_B_sel_o(fp_bsel),
    .current_pc_o(fp_pc), .rD1_o(fp_r1), .rD2_o(fp_r2), .ext_o(fp_ext),
    .alu_result_i(fp_alu), .alu_branch_i(fp_br_in),
    .resp_valid_o(fp_rv), .resp_ready_i(resp_ready),
    .resp_id_o(fp_id), .resp_result_o(fp_res), .resp_branch_o(fp_br),
    .busy_o(fp_busy)
  );

  function automatic logic [134:0] mk(input logic [4:0] op, input logic a, input logic b,
                                      input logic [31:0] pc, input logic [31:0] r1,
                                      input logic [31:0] r2, input logic [31:0] ext);
    return {op, a, b, pc, r1, r2, ext};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive point just after the rising edge; checks on the falling edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    // Reset with both requesters valid
    rst_n = 1'b0; v0 = 1'b1; v1 = 1'b1; resp_ready = 1'b1;
    d0 = mk(5'h01, 1'b1, 1'b0, 32'd100, 32'd5, 32'd7, 32'd3);
    d1 = mk(5'h02, 1'b0, 1'b1, 32'd200, 32'd10, 32'd20, 32'd4);
    step();
    sample();
    chk1("rst_rr_rdy0", rr_rdy0, 1'b0);
    chk1("rst_rr_rdy1", rr_rdy1, 1'b0);
    chk1("rst_fp_rdy0", fp_rdy0, 1'b0);
    chk1("rst_fp_rdy1", fp_rdy1, 1'b0);
    chk1("rst_rv", rr_rv, 1'b0);
    chk1("rst_busy", rr_busy, 1'b0);
    chk32("rst_opc", 32'(rr_opc), 32'd0);
    chk32("rst_pc", rr_pc, 32'd0);
    chk32("rst_res", rr_res, 32'd0);

    // Second reset edge, then release: req0 wins the first tie in both modes
    step();
    rst_n = 1'b1;
    sample();
    chk1("rel_rr_rdy0", rr_rdy0, 1'b1);
    chk1("rel_rr_rdy1", rr_rdy1, 1'b0);
    chk1("rel_fp_rdy0", fp_rdy0, 1'b1);
    chk1("rel_fp_rdy1", fp_rdy1, 1'b0);

    // T+1: execute outputs valid; requester data may change freely
    step();
    v0 = 1'b0; v1 = 1'b0;
    d0 = mk(5'h1f, 1'b0, 1'b1, 32'hdead_beef, 32'd99, 32'd98, 32'd97);
    sample();
    chk32("t1_opc", 32'(rr_opc), 32'h1);
    chk1("t1_asel", rr_asel, 1'b1);
    chk1("t1_bsel", rr_bsel, 1'b0);
    chk32("t1_pc", rr_pc, 32'd100);
    chk32("t1_rd1", rr_r1, 32'd5);
    chk32("t1_rd2", rr_r2, 32'd7);
    chk32("t1_ext", rr_ext, 32'd3);
    chk1("t1_busy", rr_busy, 1'b1);
    chk1("t1_rv", rr_rv, 1'b0);

    // T+2: response
    step();
    sample();
    chk1("t2_rv", rr_rv, 1'b1);
    chk1("t2_id", rr_id, 1'b0);
    chk32("t2_res", rr_res, 32'h0000_000c);
    chk1("t2_br", rr_br, 1'b0);
    chk32("t2_opc_hold", 32'(rr_opc), 32'h1);
    chk32("t2_fp_res", fp_res, 32'h0000_000c);

    // Back in IDLE; req1 alone with a stalled consumer
    step();
    v1 = 1'b1; resp_ready = 1'b0;
    d1 = mk(5'h02, 1'b0, 1'b1, 32'd200, 32'd10, 32'd10, 32'd4);
    sample();
    chk1("idle_rv", rr_rv, 1'b0);
    chk1("idle_busy", rr_busy, 1'b0);
    chk1("solo1_rr_rdy1", rr_rdy1, 1'b1);
    chk1("solo1_rr_rdy0", rr_rdy0, 1'b0);
    chk1("solo1_fp_rdy1", fp_rdy1, 1'b1);

    // ISSUE with a new req0 request pending
    step();
    v1 = 1'b0; v0 = 1'b1;
    d0 = mk(5'h03, 1'b0, 1'b0, 32'd300, 32'd1, 32'd2, 32'd0);
    sample();
    chk1("iss_rdy0", rr_rdy0, 1'b0);
    chk32("iss_opc", 32'(rr_opc), 32'h2);
    chk32("iss_rd2", rr_r2, 32'd10);
    chk1("iss_bsel", rr_bsel, 1'b1);

    // RESP stalled for 5 cycles: everything held, no grant
    for (int i = 0; i < 5; i++) begin
      step();
      sample();
      chk1("stall_rv", rr_rv, 1'b1);
      chk1("stall_id", rr_id, 1'b1);
      chk32("stall_res", rr_res, 32'd20);
      chk1("stall_br", rr_br, 1'b1);
      chk1("stall_rdy0", rr_rdy0, 1'b0);
      chk1("stall_fp_rdy0", fp_rdy0, 1'b0);
      chk1("stall_busy", rr_busy, 1'b1);
      chk32("stall_opc", 32'(rr_opc), 32'h2);
    end

    // Consumer accepts: still no grant in that cycle
    step();
    resp_ready = 1'b1;
    sample();
    chk1("acc_rv", rr_rv, 1'b1);
    chk1("acc_rdy0", rr_rdy0, 1'b0);

    // First IDLE cycle: pending req0 granted
    step();
    sample();
    chk1("next_rr_rdy0", rr_rdy0, 1'b1);
    chk1("next_fp_rdy0", fp_rdy0, 1'b1);
    chk1("next_rv", rr_rv, 1'b0);

    // ISSUE of the op that reset will abandon
    step();
    v0 = 1'b0; resp_ready = 1'b0;
    sample();
    chk32("ab_opc", 32'(rr_opc), 32'h3);
    chk32("ab_rd1", rr_r1, 32'd1);

    // RESP, then assert reset for one cycle
    step();
    rst_n = 1'b0;
    sample();
    chk1("ab_rv", rr_rv, 1'b1);
    chk32("ab_res", rr_res, 32'd3);

    // After the reset edge: all cleared; start continuous contention
    step();
    rst_n = 1'b1; v0 = 1'b1; v1 = 1'b1; resp_ready = 1'b1;
    d0 = mk(5'h01, 1'b1, 1'b0, 32'd100, 32'd5, 32'd7, 32'd3);
    d1 = mk(5'h02, 1'b0, 1'b1, 32'd200, 32'd10, 32'd20, 32'd4);
    sample();
    chk1("ar_rv", rr_rv, 1'b0);
    chk1("ar_busy", rr_busy, 1'b0);
    chk1("ar_id", rr_id, 1'b0);
    chk32("ar_res", rr_res, 32'd0);
    chk32("ar_opc", 32'(rr_opc), 32'd0);
    chk32("ar_pc", rr_pc, 32'd0);
    chk1("ar_fp_rv", fp_rv, 1'b0);

    // Both valid every cycle: RR alternates 0,1,0,1; fixed priority always 0
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin
        step();
        sample();
      end
      chk1("rr_rdy0", rr_rdy0, (i % 3 == 0) && ((i / 3) % 2 == 0));
      chk1("rr_rdy1", rr_rdy1, (i % 3 == 0) && ((i / 3) % 2 == 1));
      chk1("fp_rdy0", fp_rdy0, (i % 3 == 0));
      chk1("fp_rdy1", fp_rdy1, 1'b0);
      chk1("rr_busy", rr_busy, (i % 3 != 0));
      if (i % 3 == 2) begin
        chk1("rr_resp_id", rr_id, 1'((i / 3) % 2));
        chk32("rr_resp_res", rr_res, ((i / 3) % 2 == 1) ? 32'd30 : 32'd12);
        chk1("fp_resp_id", fp_id, 1'b0);
        chk32("fp_resp_res", fp_res, 32'd12);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_arbiter.md
EXEC_ARBITER -- requirements
Module: exec_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1; 1 = round-robin arbitration, 0 = fixed priority with req0 highest.
REQ-002 SHALL have port clk_i, input, 1; the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n_i, input, 1; reset, synchronous and active-low.
REQ-004 SHALL have port req0_valid_i, input, 1; requester 0 has an operation pending.
REQ-005 SHALL have port req0_ready_o, output, 1; requester 0 operation accepted this cycle.
REQ-006 SHALL have port req0_data_i, input, 135; requester 0 packed operation.
REQ-007 SHALL have ports req1_valid_i (input, 1), req1_ready_o (output, 1) and req1_data_i (input, 135); these are the requester 1 equivalents of REQ-004 to REQ-006.
REQ-008 SHALL have port alu_opcode_o, output, 5; ALU opcode to the execute stage.
REQ-009 SHALL have ports op_A_sel_o and op_B_sel_o, output, 1 each; execute operand selects.
REQ-010 SHALL have ports current_pc_o, rD1_o, rD2_o and ext_o, output, 32 each; execute operands.
REQ-011 SHALL have ports alu_result_i (input, 32) and alu_branch_i (input, 1); execute-stage results, combinational from the outputs above.
REQ-012 SHALL have ports resp_valid_o (output, 1) and resp_ready_i (input, 1); response handshake.
REQ-013 SHALL have ports resp_id_o (output, 1), resp_result_o (output, 32) and resp_branch_o (output, 1); response payload.
REQ-014 SHALL have port busy_o, output, 1; high when the FSM is not in IDLE.

Function
REQ-015 SHALL unpack the payload as follows: [134:130] opcode, [129] A sel, [128] B sel, [127:96] pc, [95:64] rD1, [63:32] rD2, [31:0] ext.
REQ-016 SHALL implement an FSM with states IDLE, ISSUE and RESP, with transitions IDLE->ISSUE, ISSUE->RESP and RESP->IDLE only.
REQ-017 SHALL, in IDLE, assert combinationally the ready of exactly one valid requester; no ready in ISSUE or RESP, and never both readies in the same cycle.
REQ-018 SHALL grant the only valid requester when just one is valid.
REQ-019 SHALL, when both requesters are valid, grant the requester not granted last if RR_EN=1, and grant req0 if RR_EN=0.
REQ-020 SHALL, on a handshake (valid & ready) in IDLE, register the payload, the id (0 or 1) and the last-grant flag, then enter ISSUE.
REQ-021 SHALL drive the execute outputs (REQ-008 to REQ-010) from the payload register only, holding them unchanged in IDLE and RESP.
REQ-022 SHALL remain in ISSUE for exactly one cycle, capture alu_result_i and alu_branch_i at its end into the response registers, then enter RESP.
REQ-023 SHALL, in RESP, hold resp_valid_o=1 with resp_id_o, resp_result_o and resp_branch_o stable until resp_ready_i=1, then return to IDLE.
REQ-024 SHALL have a latency of handshake cycle T -> execute outputs valid at T+1 -> resp_valid_o at T+2; minimum 3 cycles per operation.
REQ-025 SHALL not change state or registers when a requester drops valid in IDLE without a handshake.
REQ-026 SHALL not require requester data to stay stable after its handshake cycle.
REQ-027 SHALL evaluate arbitration afresh in the first IDLE cycle after RESP completes; it SHALL NOT grant in the cycle resp_ready_i is sampled.

Reset
REQ-028 SHALL, while rst_n_i=0 at a clock edge, go to IDLE, clear the payload and response registers and all outputs to 0, and set last-grant to 1 so req0 wins the first tie.
REQ-029 SHALL give reset priority over every handshake; reset during ISSUE or RESP abandons the operation with no response, and resp_valid_o is 0 after that edge.
REQ-030 SHALL keep the readies low while rst_n_i=0.

Verification
REQ-031 SHALL pass this test: rst_n_i low 2 cycles with both valid -> readies 0, all outputs 0; first cycle after release -> req0_ready_o=1.
REQ-032 SHALL pass this test: req0 alone, opcode 5'h01, rD1=5, rD2=7, ALU stub returns 0x0000000C -> alu_opcode_o=5'h01 at T+1; resp_valid_o=1, resp_id_o=0, resp_result_o=0x0000000C at T+2.
REQ-033 SHALL pass this test: both valid continuously, RR_EN=1, resp_ready_i=1 -> grant order 0,1,0,1, one grant every 3 cycles.
REQ-034 SHALL pass this test: same stimulus with RR_EN=0 -> every grant to req0; req1_ready_o never 1.
REQ-035 SHALL pass this test: resp_ready_i low for 5 cycles in RESP with a new request pending -> resp_valid_o and payload held stable, no ready asserted, busy_o=1.
REQ-036 SHALL pass this test: rst_n_i low for one cycle while in RESP -> next cycle resp_valid_o=0, busy_o=0, all outputs 0, no response issued.
